// File: rtl/prbs16_checker_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | prbs16_checker_if: received-word bus and status outputs of the checker    |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
interface prbs16_checker_if #(
  parameter int LANES = 4,
  parameter int ERR_W = 16
);
  logic                   in_valid;
  logic [16*LANES-1:0]    in_data;
  logic                   clear_cnt;
  logic [LANES-1:0]       lock;
  logic [LANES-1:0]       err_pulse;
  logic [ERR_W*LANES-1:0] err_count;

  modport master (
    output in_valid, in_data, clear_cnt,
    input  lock, err_pulse, err_count
  );

  modport slave (
    input  in_valid, in_data, clear_cnt,
    output lock, err_pulse, err_count
  );
endinterface
`default_nettype wire

// File: rtl/prbs16_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | prbs16_checker: per-lane self-synchronising x16 LFSR pattern checker      |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module prbs16_checker #(
  parameter int LANES         = 4,
  parameter int GOOD_TO_LOCK  = 8,
  parameter int BAD_TO_UNLOCK = 4,
  parameter int ERR_W         = 16
) (
  input  logic            clk,
  input  logic            reset,
  prbs16_checker_if.slave bus
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int GW = $clog2(GOOD_TO_LOCK + 1);
  localparam int BW = $clog2(BAD_TO_UNLOCK + 1);
  localparam logic [GW-1:0] c_good_last = GW'(GOOD_TO_LOCK - 1);
  localparam logic [BW-1:0] c_bad_last  = BW'(BAD_TO_UNLOCK - 1);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    state_t            state_q, state_d;
    logic [15:0]       ref_word_q, ref_word_d;
    logic [GW-1:0]     good_q, good_d;
    logic [BW-1:0]     bad_q, bad_d;
    logic              lock_q, lock_d;
    logic              err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]  err_count_q, err_count_d;
    logic [15:0]       lane_data;
    logic [15:0]       exp_word;

    assign lane_data = bus.in_data[16*i +: 16];
    assign exp_word  = {ref_word_q[14:0],
                        ref_word_q[3] ^ ref_word_q[12] ^ ref_word_q[14] ^ ref_word_q[15]};

    always_comb begin
      state_d     = state_q;
      ref_word_d  = ref_word_q;
      good_d      = good_q;
      bad_d       = bad_q;
      err_pulse_d = 1'b0;
      err_count_d = err_count_q;

      if (bus.in_valid) begin
        case (state_q)
          HUNT: begin
            // All-zero is the LFSR's lock-up state, so it can never seed.
            if (lane_data != 16'h0000) begin
              ref_word_d = lane_data;
              good_d     = '0;
              state_d    = SYNC;
            end
          end
          SYNC: begin
            if (lane_data == exp_word) begin
              ref_word_d = lane_data;
              if (good_q == c_good_last) begin
                good_d  = '0;
                bad_d   = '0;
                state_d = LOCKED;
              end else begin
                good_d = good_q + GW'(1);
              end
            end else begin
              ref_word_d = lane_data;
              good_d     = '0;
              if (lane_data == 16'h0000) begin
                state_d = HUNT;
              end
            end
          end
          LOCKED: begin
            if (lane_data == exp_word) begin
              ref_word_d = lane_data;
              bad_d      = '0;
            end else begin
              // Flywheel: keep running the local sequence through isolated errors.
              ref_word_d  = exp_word;
              err_pulse_d = 1'b1;
              if (err_count_q != {ERR_W{1'b1}}) begin
                err_count_d = err_count_q + ERR_W'(1);
              end
              if (bad_q == c_bad_last) begin
                bad_d   = '0;
                state_d = HUNT;
              end else begin
                bad_d = bad_q + BW'(1);
              end
            end
          end
          default: begin
            state_d = HUNT;
          end
        endcase
      end

      if (bus.clear_cnt) begin
        err_count_d = '0;
      end
      lock_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q     <= HUNT;
        ref_word_q  <= '0;
        good_q      <= '0;
        bad_q       <= '0;
        lock_q      <= 1'b0;
        err_pulse_q <= 1'b0;
        err_count_q <= '0;
      end else begin
        state_q     <= state_d;
        ref_word_q  <= ref_word_d;
        good_q      <= good_d;
        bad_q       <= bad_d;
        lock_q      <= lock_d;
        err_pulse_q <= err_pulse_d;
        err_count_q <= err_count_d;
      end
    end

    assign bus.lock[i]                   = lock_q;
    assign bus.err_pulse[i]              = err_pulse_q;
    assign bus.err_count[ERR_W*i +: ERR_W] = err_count_q;
  end

endmodule
`default_nettype wire
